l2_arbiter: RTL

// Shares the single L2 cache port between the instruction cache (read-only)
// and the data cache (line fills plus dirty-line writebacks). Sits between

---
 rtl/l2_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the icache (reads) and the dcache
// (fills and writebacks). One transfer at a time. Round-robin between the
// clients, except that a dcache writeback is immediately followed by its fill.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_read_i,
  input  logic [ADDR_WIDTH-1:0] icache_addr_i,
  output logic                  icache_ack_o,
  input  logic                  dcache_read_i,
  input  logic                  dcache_write_i,
  input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache_data_i,
  output logic                  dcache_ack_o,
  output logic [LINE_WIDTH-1:0] client_data_o,
  output logic [1:0]            grant_o,
  output logic                  l2_read_o,
  output logic                  l2_write_o,
  output logic [ADDR_WIDTH-1:0] l2_addr_o,
  output logic [LINE_WIDTH-1:0] l2_data_o,
  input  logic                  l2_ack_i,
  input  logic [LINE_WIDTH-1:0] l2_data_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rr_ptr;   // 0: icache preferred, 1: dcache preferred
  logic                  r_lock;     // writeback just finished; its fill goes next
  logic [1:0]            r_grant;
  logic                  r_read;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_data;

  logic w_i_req;
  logic w_d_req;
  logic w_any_req;
  logic w_pick_d;
  logic w_op_write;

  assign w_i_req   = icache_read_i;
  assign w_d_req   = dcache_read_i | dcache_write_i;
  assign w_any_req = w_i_req | w_d_req;
  // dcache wins on lock, when it is alone, or when the pointer favours it.
  assign w_pick_d   = w_d_req & (r_lock | ~w_i_req | r_rr_ptr);
  // A simultaneous writeback and fill always starts with the writeback.
  assign w_op_write = w_pick_d & dcache_write_i;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: grab the port on any request, release it on the L2 ack.
  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_next = ST_BUSY;
      ST_BUSY: if (l2_ack_i)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant, strobe and transfer registers plus the fairness bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
      r_lock   <= 1'b0;
      r_grant  <= 2'b00;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An idle cycle without a dcache request releases the lock so the
          // icache cannot be starved.
          if (!w_d_req) r_lock <= 1'b0;
          if (w_any_req) begin
            r_grant <= w_pick_d ? 2'b10 : 2'b01;
            r_addr  <= w_pick_d ? dcache_addr_i : icache_addr_i;
            r_read  <= ~w_op_write;
            r_write <= w_op_write;
            if (w_op_write) r_data <= dcache_data_i;
          end
        end
        ST_BUSY: begin
          if (l2_ack_i) begin
            r_grant  <= 2'b00;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_rr_ptr <= r_grant[0];
            r_lock   <= r_grant[1] & r_write;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign l2_read_o     = r_read;
  assign l2_write_o    = r_write;
  assign l2_addr_o     = r_addr;
  assign l2_data_o     = r_data;
  assign client_data_o = l2_data_i;
  // The L2 ack is steered to the granted client only; none while in reset.
  assign icache_ack_o  = l2_ack_i & r_grant[0] & ~reset;
  assign dcache_ack_o  = l2_ack_i & r_grant[1] & ~reset;

`ifndef SYNTHESIS
  a_one_strobe: assert property (@(posedge clk) disable iff (reset)
    !(r_read && r_write));
  a_one_grant: assert property (@(posedge clk) disable iff (reset)
    r_grant != 2'b11);
`endif

endmodule
